cp0_exc_ctrl: RTL and testbench

- Coprocessor-0 register file and exception sequencer for the 5-stage MIPS pipeline, located in the M stage.
- Consumes the merged M-stage exception code and error flag, plus the six external hardware interrupt lines.
- Decides whether to take an exception or interrupt, latches EPC/Cause/SR, raises the pipeline flush/redirect request, and services mtc0/mfc0/eret.

---
 rtl/cp0_exc_ctrl_pkg.sv | 34 +++
 rtl/cp0_req_gen.sv | 24 ++
 rtl/cp0_exc_ctrl.sv | 130 +++++++++++++
 tb/tb_cp0_exc_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_exc_ctrl_pkg.sv
// Shared definitions for the CP0 exception controller: register numbers,
// field bit positions, exception codes and the USER/KERNEL mode encoding.
package cp0_exc_ctrl_pkg;

   localparam logic [4:0] CP0_SR    = 5'd12;
   localparam logic [4:0] CP0_CAUSE = 5'd13;
   localparam logic [4:0] CP0_EPC   = 5'd14;
   localparam logic [4:0] CP0_PRID  = 5'd15;

   localparam int SR_IE        = 0;
   localparam int SR_EXL       = 1;
   localparam int SR_IM_LO     = 10;
   localparam int SR_IM_HI     = 15;
   localparam int CAUSE_EXC_LO = 2;
   localparam int CAUSE_EXC_HI = 6;
   localparam int CAUSE_IP_LO  = 10;
   localparam int CAUSE_IP_HI  = 15;
   localparam int CAUSE_BD     = 31;

   typedef enum logic [4:0] {
      EXC_INT  = 5'd0,
      EXC_ADEL = 5'd4,
      EXC_ADES = 5'd5,
      EXC_RI   = 5'd10,
      EXC_OV   = 5'd12
   } exc_code_e;

   // Mode is exactly SR.EXL: KERNEL while a handler is running.
   typedef enum logic {
      MODE_USER   = 1'b0,
      MODE_KERNEL = 1'b1
   } mode_e;

endpackage

// File: rtl/cp0_req_gen.sv
// Combinational exception/interrupt request and ExcCode selection.
// Interrupts take priority over synchronous exceptions; EXL masks both.
module cp0_req_gen
   import cp0_exc_ctrl_pkg::*;
(
   input  logic [5:0] hw_int_i,
   input  logic [5:0] im_i,
   input  logic       ie_i,
   input  logic       exl_i,
   input  logic       error_i,
   input  logic [4:0] exc_i,
   output logic       int_req_o,
   output logic [4:0] code_o
);

   logic int_pend;
   logic exc_pend;

   assign int_pend  = (|(hw_int_i & im_i)) & ie_i & ~exl_i;
   assign exc_pend  = error_i & ~exl_i;
   assign int_req_o = int_pend | exc_pend;
   assign code_o    = int_pend ? EXC_INT : exc_i;

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 register file (SR/Cause/EPC/PRId) and exception entry/return sequencing
// for the M stage of the 5-stage MIPS pipeline.
module cp0_exc_ctrl
   import cp0_exc_ctrl_pkg::*;
#(
   parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
   parameter logic [31:0] PRID_VAL     = 32'h2019_1217
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] PC_M,
   input  logic        BD_M,
   input  logic [4:0]  Exc_M,
   input  logic        error_M,
   input  logic [5:0]  HWInt,
   input  logic        cp0_we,
   input  logic [4:0]  cp0_addr,
   input  logic [31:0] cp0_wdata,
   input  logic        eret_M,
   output logic [31:0] cp0_rdata,
   output logic        IntReq,
   output logic [31:0] EPC_out,
   output logic [31:0] handler_pc
);

   mode_e       mode_q, mode_d;
   logic [5:0]  im_q, im_d;
   logic        ie_q, ie_d;
   logic        bd_q, bd_d;
   logic [5:0]  ip_q, ip_d;
   logic [4:0]  code_q, code_d;
   logic [29:0] epc_q, epc_d;

   logic        exl;
   logic [4:0]  sel_code;
   logic [29:0] victim_pc;
   logic        unused_pc;

   assign exl = (mode_q == MODE_KERNEL);

   cp0_req_gen u_req_gen (
      .hw_int_i (HWInt),
      .im_i     (im_q),
      .ie_i     (ie_q),
      .exl_i    (exl),
      .error_i  (error_M),
      .exc_i    (Exc_M),
      .int_req_o(IntReq),
      .code_o   (sel_code)
   );

   // A delay-slot victim restarts at its branch, one word earlier.
   assign victim_pc = BD_M ? (PC_M[31:2] - 30'd1) : PC_M[31:2];
   assign unused_pc = ^PC_M[1:0];

   always_comb begin
      mode_d = mode_q;
      im_d   = im_q;
      ie_d   = ie_q;
      bd_d   = bd_q;
      ip_d   = HWInt;
      code_d = code_q;
      epc_d  = epc_q;
      if (IntReq) begin
         // The M instruction is flushed, so its mtc0/eret must not land.
         mode_d = MODE_KERNEL;
         code_d = sel_code;
         bd_d   = BD_M;
         epc_d  = victim_pc;
      end else begin
         if (cp0_we) begin
            case (cp0_addr)
               CP0_SR: begin
                  im_d   = cp0_wdata[SR_IM_HI:SR_IM_LO];
                  ie_d   = cp0_wdata[SR_IE];
                  mode_d = cp0_wdata[SR_EXL] ? MODE_KERNEL : MODE_USER;
               end
               CP0_EPC: epc_d = cp0_wdata[31:2];
               default: ;
            endcase
         end
         if (eret_M) begin
            mode_d = MODE_USER;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode_q <= MODE_USER;
         im_q   <= '0;
         ie_q   <= 1'b0;
         bd_q   <= 1'b0;
         ip_q   <= '0;
         code_q <= '0;
         epc_q  <= '0;
      end else begin
         mode_q <= mode_d;
         im_q   <= im_d;
         ie_q   <= ie_d;
         bd_q   <= bd_d;
         ip_q   <= ip_d;
         code_q <= code_d;
         epc_q  <= epc_d;
      end
   end

   always_comb begin
      cp0_rdata = '0;
      case (cp0_addr)
         CP0_SR: begin
            cp0_rdata[SR_IM_HI:SR_IM_LO] = im_q;
            cp0_rdata[SR_EXL]            = exl;
            cp0_rdata[SR_IE]             = ie_q;
         end
         CP0_CAUSE: begin
            cp0_rdata[CAUSE_BD]                   = bd_q;
            cp0_rdata[CAUSE_IP_HI:CAUSE_IP_LO]    = ip_q;
            cp0_rdata[CAUSE_EXC_HI:CAUSE_EXC_LO]  = code_q;
         end
         CP0_EPC:  cp0_rdata = {epc_q, 2'b00};
         CP0_PRID: cp0_rdata = PRID_VAL;
         default:  cp0_rdata = '0;
      endcase
   end

   assign EPC_out    = {epc_q, 2'b00};
   assign handler_pc = HANDLER_ADDR;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed self-checking bench for cp0_exc_ctrl: entry, masking, eret,
// mtc0 semantics and collisions between them.
module tb_cp0_exc_ctrl;

   logic        clk;
   logic        reset;
   logic [31:0] PC_M;
   logic        BD_M;
   logic [4:0]  Exc_M;
   logic        error_M;
   logic [5:0]  HWInt;
   logic        cp0_we;
   logic [4:0]  cp0_addr;
   logic [31:0] cp0_wdata;
   logic        eret_M;
   logic [31:0] cp0_rdata;
   logic        IntReq;
   logic [31:0] EPC_out;
   logic [31:0] handler_pc;

   int n_checks = 0;
   int n_fail   = 0;

   cp0_exc_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .PC_M      (PC_M),
      .BD_M      (BD_M),
      .Exc_M     (Exc_M),
      .error_M   (error_M),
      .HWInt     (HWInt),
      .cp0_we    (cp0_we),
      .cp0_addr  (cp0_addr),
      .cp0_wdata (cp0_wdata),
      .eret_M    (eret_M),
      .cp0_rdata (cp0_rdata),
      .IntReq    (IntReq),
      .EPC_out   (EPC_out),
      .handler_pc(handler_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      PC_M = 32'h0; BD_M = 1'b0; Exc_M = 5'd0; error_M = 1'b0;
      cp0_we = 1'b0; cp0_addr = 5'd0; cp0_wdata = 32'h0; eret_M = 1'b0;
   endtask

   task automatic test_reset();
      cp0_we = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'h0000_1234;
      tick();
      idle();
      reset = 1'b1;
      #2;
      n_checks++;
      if (EPC_out !== 32'h0) begin
         n_fail++; $display("FAIL reset_async_epc: got %h want %h", EPC_out, 32'h0);
      end
      reset = 1'b0;
      #1;
      for (int a = 12; a <= 14; a++) begin
         cp0_addr = a[4:0];
         #1;
         n_checks++;
         if (cp0_rdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_read_%0d: got %h want %h", a, cp0_rdata, 32'h0);
         end
      end
      n_checks++;
      if (IntReq !== 1'b0) begin
         n_fail++; $display("FAIL reset_intreq: got %b want 0", IntReq);
      end
      cp0_addr = 5'd15;
      #1;
      n_checks++;
      if (cp0_rdata !== 32'h2019_1217) begin
         n_fail++; $display("FAIL prid: got %h want %h", cp0_rdata, 32'h2019_1217);
      end
      n_checks++;
      if (handler_pc !== 32'h0000_4180) begin
         n_fail++; $display("FAIL handler_pc: got %h want %h", handler_pc, 32'h0000_4180);
      end
      $display("reset: done");
   endtask

   task automatic test_interrupt();
      cp0_we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_FC01;
      tick();
      idle();
      cp0_addr = 5'd12;
      #1;
      n_checks++;
      if (cp0_rdata !== 32'h0000_FC01) begin
         n_fail++; $display("FAIL sr_write: got %h want %h", cp0_rdata, 32'h0000_FC01);
      end
      HWInt = 6'b000100; PC_M = 32'h0000_1000;
      #1;
      n_checks++;
      if (IntReq !== 1'b1) begin
         n_fail++; $display("FAIL int_req: got %b want 1", IntReq);
      end
      tick();
      cp0_addr = 5'd13;
      #1;
      n_checks++;
      if (cp0_rdata !== 32'h0000_1000) begin
         n_fail++; $display("FAIL int_cause: got %h want %h", cp0_rdata, 32'h0000_1000);
      end
      cp0_addr = 5'd12;
      #1;
      n_checks++;
      if (cp0_rdata !== 32'h0000_FC03) begin
         n_fail++; $display("FAIL int_sr_exl: got %h want %h", cp0_rdata, 32'h0000_FC03);
      end
      n_checks++;
      if (EPC_out !== 32'h0000_1000) begin
         n_fail++; $display("FAIL int_epc: got %h want %h", EPC_out, 32'h0000_1000);
      end
      n_checks++;
      if (IntReq !== 1'b0) begin
         n_fail++; $display("FAIL int_masked_after_entry: got %b want 0", IntReq);
      end
      $display("interrupt entry: done");
   endtask

   task automatic test_masked();
      error_M = 1'b1; Exc_M = 5'd12; HWInt = 6'b111111; PC_M = 32'h0000_5000;
      #1;
      n_checks++;
      if (IntReq !== 1'b0) begin
         n_fail++; $display("FAIL nested_masked: got %b want 0", IntReq);
      end
      tick();
      cp0_addr = 5'd13;
      #1;
      n_checks++;
      if (cp0_rdata !== 32'h0000_FC00) begin
         n_fail++; $display("FAIL ip_tracks: got %h want %h", cp0_rdata, 32'h0000_FC00);
      end
      n_checks++;
      if (EPC_out !== 32'h0000_1000) begin
         n_fail++; $display("FAIL nested_epc_kept: got %h want %h", EPC_out, 32'h0000_1000);
      end
      idle();
      HWInt = 6'b000000;
      $display("nested masking: done");
   endtask

   task automatic test_eret();
      eret_M = 1'b1;
      #1;
      n_checks++;
      if (EPC_out !== 32'h0000_1000 || IntReq !== 1'b0) begin
         n_fail++; $display("FAIL eret_cycle: got epc %h req %b want %h 0", EPC_out, IntReq, 32'h0000_1000);
      end
      tick();
      eret_M = 1'b0;
      cp0_addr = 5'd12;
      #1;
      n_checks++;
      if (cp0_rdata !== 32'h0000_FC01) begin
         n_fail++; $display("FAIL eret_sr: got %h want %h", cp0_rdata, 32'h0000_FC01);
      end
      n_checks++;
      if (EPC_out !== 32'h0000_1000) begin
         n_fail++; $display("FAIL eret_epc_kept: got %h want %h", EPC_out, 32'h0000_1000);
      end
      $display("eret: done");
   endtask

   task automatic test_exception();
      error_M = 1'b1; Exc_M = 5'd12; BD_M = 1'b1; PC_M = 32'h0000_3010;
      #1;
      n_checks++;
      if (IntReq !== 1'b1) begin
         n_fail++; $display("FAIL exc_req: got %b want 1", IntReq);
      end
      tick();
      idle();
      n_checks++;
      if (EPC_out !== 32'h0000_300C) begin
         n_fail++; $display("FAIL exc_bd_epc: got %h want %h", EPC_out, 32'h0000_300C);
      end
      cp0_addr = 5'd13;
      #1;
      n_checks++;
      if (cp0_rdata !== 32'h8000_0030) begin
         n_fail++; $display("FAIL exc_cause: got %h want %h", cp0_rdata, 32'h8000_0030);
      end
      cp0_addr = 5'd12;
      #1;
      n_checks++;
      if (cp0_rdata !== 32'h0000_FC03) begin
         n_fail++; $display("FAIL exc_sr: got %h want %h", cp0_rdata, 32'h0000_FC03);
      end
      eret_M = 1'b1;
      tick();
      eret_M = 1'b0;
      $display("exception entry: done");
   endtask

   task automatic test_eret_vs_int();
      HWInt = 6'b000001; eret_M = 1'b1; PC_M = 32'h0000_2000;
      #1;
      n_checks++;
      if (IntReq !== 1'b1) begin
         n_fail++; $display("FAIL eret_int_req: got %b want 1", IntReq);
      end
      tick();
      idle();
      HWInt = 6'b000000;
      cp0_addr = 5'd12;
      #1;
      n_checks++;
      if (cp0_rdata !== 32'h0000_FC03) begin
         n_fail++; $display("FAIL eret_int_exl: got %h want %h", cp0_rdata, 32'h0000_FC03);
      end
      cp0_addr = 5'd13;
      #1;
      n_checks++;
      if (cp0_rdata !== 32'h0000_0400) begin
         n_fail++; $display("FAIL eret_int_cause: got %h want %h", cp0_rdata, 32'h0000_0400);
      end
      n_checks++;
      if (EPC_out !== 32'h0000_2000) begin
         n_fail++; $display("FAIL eret_int_epc: got %h want %h", EPC_out, 32'h0000_2000);
      end
      eret_M = 1'b1;
      tick();
      eret_M = 1'b0;
      $display("eret vs interrupt: done");
   endtask

   task automatic test_mtc0();
      cp0_we = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'h0000_3007;
      #1;
      n_checks++;
      if (cp0_rdata !== 32'h0000_2000) begin
         n_fail++; $display("FAIL read_pre_write: got %h want %h", cp0_rdata, 32'h0000_2000);
      end
      tick();
      cp0_we = 1'b0;
      #1;
      n_checks++;
      if (cp0_rdata !== 32'h0000_3004) begin
         n_fail++; $display("FAIL epc_write: got %h want %h", cp0_rdata, 32'h0000_3004);
      end
      cp0_we = 1'b1; cp0_addr = 5'd13; cp0_wdata = 32'hFFFF_FFFF;
      tick();
      cp0_addr = 5'd15; cp0_wdata = 32'h0;
      tick();
      cp0_addr = 5'd5; cp0_wdata = 32'hDEAD_BEEF;
      tick();
      cp0_we = 1'b0;
      #1;
      n_checks++;
      if (cp0_rdata !== 32'h0) begin
         n_fail++; $display("FAIL unmapped_read: got %h want %h", cp0_rdata, 32'h0);
      end
      cp0_addr = 5'd13;
      #1;
      n_checks++;
      if (cp0_rdata !== 32'h0) begin
         n_fail++; $display("FAIL cause_readonly: got %h want %h", cp0_rdata, 32'h0);
      end
      cp0_addr = 5'd15;
      #1;
      n_checks++;
      if (cp0_rdata !== 32'h2019_1217) begin
         n_fail++; $display("FAIL prid_readonly: got %h want %h", cp0_rdata, 32'h2019_1217);
      end
      $display("mtc0 semantics: done");
   endtask

   task automatic test_back_to_back();
      HWInt = 6'b000010; PC_M = 32'h0000_4000;
      cp0_we = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'h0000_5550;
      #1;
      n_checks++;
      if (IntReq !== 1'b1) begin
         n_fail++; $display("FAIL drop_req: got %b want 1", IntReq);
      end
      tick();
      n_checks++;
      if (EPC_out !== 32'h0000_4000) begin
         n_fail++; $display("FAIL mtc0_dropped: got %h want %h", EPC_out, 32'h0000_4000);
      end
      // Clear EXL by mtc0 while the interrupt is still pending.
      cp0_addr = 5'd12; cp0_wdata = 32'h0000_FC01; PC_M = 32'h0000_4100;
      #1;
      n_checks++;
      if (IntReq !== 1'b0) begin
         n_fail++; $display("FAIL exl_clear_same_cycle: got %b want 0", IntReq);
      end
      tick();
      cp0_we = 1'b0;
      #1;
      n_checks++;
      if (IntReq !== 1'b1) begin
         n_fail++; $display("FAIL exl_clear_next_cycle: got %b want 1", IntReq);
      end
      tick();
      n_checks++;
      if (EPC_out !== 32'h0000_4100) begin
         n_fail++; $display("FAIL reentry_epc: got %h want %h", EPC_out, 32'h0000_4100);
      end
      idle();
      HWInt = 6'b000000;
      $display("back to back: done");
   endtask

   initial begin
      reset = 1'b1;
      HWInt = 6'b0;
      idle();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      tick();
      test_reset();
      test_interrupt();
      test_masked();
      test_eret();
      test_exception();
      test_eret_vs_int();
      test_mtc0();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
